ctrl_hazard_tracker: RTL and testbench

//  Parametrised control-hazard unit for the pipelined core; generalises the per-stage opcode compare to a DEPTH-deep tracker.

---
 rtl/ctrl_hazard_tracker_pkg.sv | 29 ++
 rtl/ctrl_hazard_tracker_if.sv | 29 ++
 rtl/ctrl_hazard_tracker_op_decode.sv | 19 +
 rtl/ctrl_hazard_tracker.sv | 113 +++++++++++
 tb/tb_ctrl_hazard_tracker.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_hazard_tracker_pkg.sv
// ctrl_haz_pkg: shared opcode-class constants, per-opcode encodings and the
// layout of one tracked control-flow entry. Used by the hazard tracker, the
// opcode decoder and the forwarding unit.
package ctrl_haz_pkg;

  // Top three opcode bits select the instruction class
  localparam logic [2:0] BR_CLASS  = 3'b011;
  localparam logic [2:0] JMP_CLASS = 3'b001;

  // Conditional branches
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;

  // Unconditional jumps
  localparam logic [4:0] OP_J    = 5'b00100;
  localparam logic [4:0] OP_JR   = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;

  // One pipeline slot: is something in flight there, and is it a jump
  // (jumps can never be released early by a branch resolution)
  typedef struct packed {
    logic valid;
    logic is_jump;
  } haz_entry_t;

endpackage

// File: rtl/ctrl_hazard_tracker_if.sv
// ctrl_hazard_tracker_if: pipeline-side signals of the control-hazard tracker.
// master = pipeline control driving the tracker, slave = the tracker itself.
interface ctrl_hazard_tracker_if #(
  parameter int OPW   = 5,
  parameter int DEPTH = 3,
  parameter int CNTW  = 16
);
  localparam int PW = $clog2(DEPTH + 1);

  logic             if_valid;
  logic [OPW-1:0]   if_opcode;
  logic             advance;
  logic             flush;
  logic             branch_resolved;
  logic             branch_taken;
  logic             stall_fetch;
  logic [PW-1:0]    pending;
  logic [CNTW-1:0]  stall_cnt;

  modport master (
    output if_valid, if_opcode, advance, flush, branch_resolved, branch_taken,
    input  stall_fetch, pending, stall_cnt
  );

  modport slave (
    input  if_valid, if_opcode, advance, flush, branch_resolved, branch_taken,
    output stall_fetch, pending, stall_cnt
  );
endinterface

// File: rtl/ctrl_hazard_tracker_op_decode.sv
// ctrl_op_decode: pure combinational opcode classifier. Only the three class
// bits at the top of the opcode matter; the low bits pick the variant.
module ctrl_op_decode
  import ctrl_haz_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output logic           is_branch,
  output logic           is_jump
);

  logic [2:0] op_class;

  assign op_class  = opcode[OPW-1:OPW-3];
  assign is_branch = (op_class == BR_CLASS);
  assign is_jump   = (op_class == JMP_CLASS);

endmodule

// File: rtl/ctrl_hazard_tracker.sv
// ctrl_hazard_tracker: tracks control-flow instructions through DEPTH stages
// after IF/ID and holds fetch while any of them is in flight. A not-taken
// branch is released when it resolves at entry RES_STAGE; jumps and taken
// branches ride to the end of the tracked pipe.
// Optional build macro CTRL_HAZ_PERF_EN adds the saturating stall_cnt
// counter; without it stall_cnt is constant zero.
module ctrl_hazard_tracker
  import ctrl_haz_pkg::*;
#(
  parameter int OPW       = 5,
  parameter int DEPTH     = 3,
  parameter int RES_STAGE = 1,
  parameter int CNTW      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ctrl_hazard_tracker_if.slave  bus
);

  localparam int PW = $clog2(DEPTH + 1);

  // When the pipe advances, a resolved entry has already moved one slot
  // down; if it was in the last slot it is retiring anyway.
  localparam bit CLR_SHIFT_EN  = (RES_STAGE < DEPTH - 1);
  localparam int CLR_SHIFT_IDX = CLR_SHIFT_EN ? RES_STAGE + 1 : RES_STAGE;

  haz_entry_t [DEPTH-1:0] entry_reg;
  haz_entry_t [DEPTH-1:0] entry_next;
  haz_entry_t             head_entry;

  logic          dec_branch;
  logic          dec_jump;
  logic          push_cf;
  logic          resolve_clr;
  logic          any_valid;
  logic [PW-1:0] pending_cnt;
  logic          stall;

  ctrl_op_decode #(.OPW(OPW)) u_op_decode (
    .opcode    (bus.if_opcode),
    .is_branch (dec_branch),
    .is_jump   (dec_jump)
  );

  assign push_cf            = bus.if_valid & (dec_branch | dec_jump);
  assign head_entry.valid   = push_cf;
  assign head_entry.is_jump = bus.if_valid & dec_jump;

  // Only a not-taken outcome on a real branch frees its slot early
  assign resolve_clr = bus.branch_resolved & ~bus.branch_taken &
                       entry_reg[RES_STAGE].valid & ~entry_reg[RES_STAGE].is_jump;

  // Next entry state: flush beats everything, then shift/hold, then resolve
  always_comb begin
    entry_next = entry_reg;
    if (bus.flush) begin
      entry_next = '0;
    end else begin
      if (bus.advance) begin
        entry_next = {entry_reg[DEPTH-2:0], head_entry};
      end
      if (resolve_clr) begin
        if (!bus.advance) begin
          entry_next[RES_STAGE] = '0;
        end else if (CLR_SHIFT_EN) begin
          entry_next[CLR_SHIFT_IDX] = '0;
        end
      end
    end
  end

  // Entry shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_reg <= '0;
    end else begin
      entry_reg <= entry_next;
    end
  end

  // Count and OR of valid bits, from registered state only
  always_comb begin
    pending_cnt = '0;
    any_valid   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_cnt = pending_cnt + PW'(entry_reg[i].valid);
      any_valid   = any_valid | entry_reg[i].valid;
    end
  end

  // The IF/ID term lets a fresh branch/jump stall fetch in the same cycle
  assign stall           = push_cf | any_valid;
  assign bus.stall_fetch = stall;
  assign bus.pending     = pending_cnt;

`ifdef CTRL_HAZ_PERF_EN
  logic [CNTW-1:0] stall_cnt_reg;

  // Saturating stall-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall && !(&stall_cnt_reg)) begin
      stall_cnt_reg <= stall_cnt_reg + CNTW'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_reg;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_hazard_tracker.sv
// tb_ctrl_hazard_tracker: directed control-hazard scenarios plus randomized
// traffic checked against a list-of-instructions reference model.
module tb_ctrl_hazard_tracker;
  import ctrl_haz_pkg::*;

  localparam int OPW       = 5;
  localparam int DEPTH     = 3;
  localparam int RES_STAGE = 1;
  localparam int CNTW      = 16;
  localparam int CNT_MAX   = (1 << CNTW) - 1;
`ifdef CTRL_HAZ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ctrl_hazard_tracker_if #(.OPW(OPW), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  ctrl_hazard_tracker #(
    .OPW(OPW), .DEPTH(DEPTH), .RES_STAGE(RES_STAGE), .CNTW(CNTW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: list of in-flight control-flow instructions, each with
  // the stage it currently occupies (0 = ID/EX) and whether it is a jump.
  typedef struct {
    int age;
    bit jmp;
  } inflight_t;

  inflight_t model_q[$];
  int        exp_cnt = 0;

  function automatic bit op_is_jump(logic [4:0] op);
    return (op / 4) == 1;
  endfunction

  function automatic bit op_is_cf(logic [4:0] op);
    return ((op / 4) == 1) || ((op / 4) == 3);
  endfunction

  function automatic bit exp_stall();
    return (bus.if_valid && op_is_cf(bus.if_opcode)) || (model_q.size() > 0);
  endfunction

  // Apply one clock edge to the model using the inputs currently driven
  task automatic model_step();
    inflight_t nq[$];
    inflight_t e;
    bit        killed;
    if (PERF && exp_stall() && exp_cnt < CNT_MAX) exp_cnt++;
    if (!bus.flush) begin
      foreach (model_q[k]) begin
        e = model_q[k];
        killed = bus.branch_resolved && !bus.branch_taken && !e.jmp && e.age == RES_STAGE;
        if (!killed) begin
          if (bus.advance) e.age++;
          if (e.age < DEPTH) nq.push_back(e);
        end
      end
      if (bus.advance && bus.if_valid && op_is_cf(bus.if_opcode)) begin
        e.age = 0;
        e.jmp = op_is_jump(bus.if_opcode);
        nq.push_back(e);
      end
    end
    model_q = nq;
  endtask

  task automatic set_idle();
    bus.if_valid        = 1'b0;
    bus.if_opcode       = '0;
    bus.advance         = 1'b1;
    bus.flush           = 1'b0;
    bus.branch_resolved = 1'b0;
    bus.branch_taken    = 1'b0;
  endtask

  // One clock: model update, edge, back to the falling edge
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    set_idle();
    repeat (DEPTH + 1) tick();
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.pending !== 2'd0) begin
      failures++; $display("FAIL reset_pending got=%0d exp=0", bus.pending);
    end
    checks++;
    if (bus.stall_fetch !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_fetch);
    end
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt);
    end
    bus.if_valid = 1'b1; bus.if_opcode = OP_JR;
    #1;
    checks++;
    if (bus.stall_fetch !== 1'b1) begin
      failures++; $display("FAIL reset_ifid_stall got=%b exp=1", bus.stall_fetch);
    end
    set_idle();
    rst = 1'b0;
    model_q.delete();
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_jump();
    logic [4:0] exp_st = 5'b01111;      // bit c = cycle c
    logic [1:0] exp_pd [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    for (int c = 0; c < 5; c++) begin
      set_idle();
      if (c == 0) begin bus.if_valid = 1'b1; bus.if_opcode = OP_J; end
      #1;
      checks++;
      if (bus.stall_fetch !== exp_st[c]) begin
        failures++; $display("FAIL jump_stall cyc=%0d got=%b exp=%b", c, bus.stall_fetch, exp_st[c]);
      end
      checks++;
      if (bus.pending !== exp_pd[c]) begin
        failures++; $display("FAIL jump_pending cyc=%0d got=%0d exp=%0d", c, bus.pending, exp_pd[c]);
      end
      tick();
    end
  endtask

  task automatic test_not_taken();
    logic [4:0] exp_st = 5'b00111;
    logic [1:0] exp_pd [5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
    for (int c = 0; c < 5; c++) begin
      set_idle();
      if (c == 0) begin bus.if_valid = 1'b1; bus.if_opcode = OP_BLTZ; end
      if (c == 2) begin bus.branch_resolved = 1'b1; bus.branch_taken = 1'b0; end
      #1;
      checks++;
      if (bus.stall_fetch !== exp_st[c]) begin
        failures++; $display("FAIL nt_stall cyc=%0d got=%b exp=%b", c, bus.stall_fetch, exp_st[c]);
      end
      checks++;
      if (bus.pending !== exp_pd[c]) begin
        failures++; $display("FAIL nt_pending cyc=%0d got=%0d exp=%0d", c, bus.pending, exp_pd[c]);
      end
      tick();
    end
  endtask

  // Taken branch, and a not-taken resolve aimed at a jump: both held to exit
  task automatic test_taken_and_jump_resolve();
    logic [4:0] exp_st = 5'b01111;
    logic [1:0] exp_pd [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 5; c++) begin
        set_idle();
        if (c == 0) begin bus.if_valid = 1'b1; bus.if_opcode = (s == 0) ? OP_BNEZ : OP_JALR; end
        if (c == 2) begin bus.branch_resolved = 1'b1; bus.branch_taken = (s == 0); end
        #1;
        checks++;
        if (bus.stall_fetch !== exp_st[c]) begin
          failures++; $display("FAIL held_stall s=%0d cyc=%0d got=%b exp=%b", s, c, bus.stall_fetch, exp_st[c]);
        end
        checks++;
        if (bus.pending !== exp_pd[c]) begin
          failures++; $display("FAIL held_pending s=%0d cyc=%0d got=%0d exp=%0d", s, c, bus.pending, exp_pd[c]);
        end
        tick();
      end
    end
  endtask

  task automatic test_advance_hold();
    logic [6:0] exp_st = 7'b0111111;
    logic [1:0] exp_pd [7] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    for (int c = 0; c < 7; c++) begin
      set_idle();
      if (c == 0) begin bus.if_valid = 1'b1; bus.if_opcode = OP_JAL; end
      if (c == 2 || c == 3) begin
        bus.advance = 1'b0;
        bus.if_valid = 1'b1; bus.if_opcode = OP_BEQZ;   // must not be pushed
      end
      #1;
      checks++;
      if (bus.stall_fetch !== exp_st[c]) begin
        failures++; $display("FAIL hold_stall cyc=%0d got=%b exp=%b", c, bus.stall_fetch, exp_st[c]);
      end
      checks++;
      if (bus.pending !== exp_pd[c]) begin
        failures++; $display("FAIL hold_pending cyc=%0d got=%0d exp=%0d", c, bus.pending, exp_pd[c]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    set_idle();
    bus.if_valid = 1'b1; bus.if_opcode = OP_J;
    tick(); tick();
    set_idle();
    bus.if_valid = 1'b1; bus.if_opcode = OP_BEQZ; bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.pending !== 2'd2) begin
      failures++; $display("FAIL flush_pre_pending got=%0d exp=2", bus.pending);
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (bus.pending !== 2'd0) begin
      failures++; $display("FAIL flush_pending got=%0d exp=0", bus.pending);
    end
    checks++;
    if (bus.stall_fetch !== 1'b0) begin
      failures++; $display("FAIL flush_stall got=%b exp=0", bus.stall_fetch);
    end
    tick();
  endtask

  task automatic test_async_reset();
    set_idle();
    bus.if_valid = 1'b1; bus.if_opcode = OP_JAL;
    tick(); tick();
    set_idle();
    #1;
    checks++;
    if (bus.pending !== 2'd2) begin
      failures++; $display("FAIL arst_pre_pending got=%0d exp=2", bus.pending);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.pending !== 2'd0) begin
      failures++; $display("FAIL arst_pending got=%0d exp=0", bus.pending);
    end
    checks++;
    if (bus.stall_fetch !== 1'b0) begin
      failures++; $display("FAIL arst_stall got=%b exp=0", bus.stall_fetch);
    end
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      failures++; $display("FAIL arst_cnt got=%0d exp=0", bus.stall_cnt);
    end
    rst = 1'b0;
    model_q.delete();
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.if_valid        = $urandom_range(0, 1);
      bus.if_opcode       = 5'($urandom_range(0, 31));
      bus.advance         = ($urandom_range(0, 3) != 0);
      bus.flush           = ($urandom_range(0, 15) == 0);
      bus.branch_resolved = ($urandom_range(0, 2) == 0);
      bus.branch_taken    = $urandom_range(0, 1);
      #1;
      checks++;
      if (bus.stall_fetch !== exp_stall()) begin
        failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, bus.stall_fetch, exp_stall());
      end
      checks++;
      if (bus.pending !== 2'(model_q.size())) begin
        failures++; $display("FAIL rnd_pending n=%0d got=%0d exp=%0d", n, bus.pending, model_q.size());
      end
      checks++;
      if (bus.stall_cnt !== 16'(exp_cnt)) begin
        failures++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, bus.stall_cnt, exp_cnt);
      end
      tick();
    end
    drain();
  endtask

  // Preload the counter by stalling, then confirm it pins at all-ones
  task automatic test_saturation();
    set_idle();
    bus.if_valid = 1'b1; bus.if_opcode = OP_J;
    repeat (CNT_MAX + 4) tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.stall_cnt !== 16'hFFFF) begin
        failures++; $display("FAIL sat_cnt cyc=%0d got=%h exp=ffff", c, bus.stall_cnt);
      end
      tick();
    end
    drain();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_jump();
    test_not_taken();
    test_taken_and_jump_resolve();
    test_advance_hold();
    test_flush();
    test_async_reset();
    test_random();
    if (PERF) test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
